mux_rr_sched: RTL and testbench

- Round-robin scheduler that shares one 4:1 byte-select datapath among four requesters (a, b, c, d).
- Each cycle it arbitrates pending requests, drives the 2-bit select (op) and captures the selected byte into a registered output.
- It presents the result downstream with a valid/ready handshake and returns a one-cycle ack to the winning requester.
- It sits between the four byte sources and the single consumer of the muxed result.

---
 rtl/mux_rr_sched_if.sv | 19 +
 rtl/mux_rr_sched.sv | 100 ++++++++++
 tb/tb_mux_rr_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mux_rr_sched_if.sv
// Bundle between four byte requesters, the round-robin scheduler and the result consumer.
interface mux_rr_sched_if #(parameter int unsigned WIDTH = 8);
  logic [3:0]       req;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       ack;
  logic [1:0]       op;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             busy;

  modport master (output req, a, b, c, d, y_ready,
                  input  ack, op, y, y_valid, busy);
  modport slave  (input  req, a, b, c, d, y_ready,
                  output ack, op, y, y_valid, busy);
endinterface

// File: rtl/mux_rr_sched.sv
// Shares one 4:1 byte-select datapath among four requesters; grants round-robin
// (or fixed priority) and hands the registered result downstream via valid/ready.
module mux_rr_sched #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PRIO_MODE = 0
) (
  input logic           clk,
  input logic           rst,
  mux_rr_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [1:0]       ptr_q, ptr_nxt;
  logic [1:0]       winner;
  logic [WIDTH-1:0] y_q, y_nxt;
  logic [WIDTH-1:0] sel_data;
  logic             vld_q, vld_nxt;

  // Reverse scan so the first set index in priority order is the last one written.
  always_comb begin
    winner = ptr_q;
    if (PRIO_MODE != 0) begin
      winner = 2'd0;
      for (int i = 3; i >= 0; i--) begin
        if (bus.req[i]) winner = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (bus.req[ptr_q + 2'(i)]) winner = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    case (op_q)
      2'd0:    sel_data = bus.a;
      2'd1:    sel_data = bus.b;
      2'd2:    sel_data = bus.c;
      default: sel_data = bus.d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= 2'd0;
      ptr_q <= 2'd0;
      y_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
      ptr_q <= ptr_nxt;
      y_q   <= y_nxt;
      vld_q <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    ptr_nxt   = ptr_q;
    y_nxt     = y_q;
    vld_nxt   = vld_q;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          op_nxt    = winner;
          state_nxt = SEL;
        end
      end
      SEL: begin
        y_nxt     = sel_data;
        vld_nxt   = 1'b1;
        ptr_nxt   = op_q + 2'd1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.y_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ack is combinational so the requester sees it in the capture cycle itself.
  assign bus.ack     = (state == SEL) ? (4'(1) << op_q) : 4'b0000;
  assign bus.op      = op_q;
  assign bus.y       = y_q;
  assign bus.y_valid = vld_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed bench for mux_rr_sched: round-robin instance driven from a vector
// table plus hand sequences; a fixed-priority instance checks priority to b.
module tb_mux_rr_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_rr_sched_if #(.WIDTH(8)) bus_rr ();
  mux_rr_sched_if #(.WIDTH(8)) bus_fp ();

  mux_rr_sched #(.WIDTH(8), .PRIO_MODE(0)) dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));
  mux_rr_sched #(.WIDTH(8), .PRIO_MODE(1)) dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy;
    logic [7:0] cval;
    logic [3:0] e_ack;
    logic [1:0] e_op;
    logic [7:0] e_y;
    logic       e_vld;
    logic       e_busy;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic r, logic [3:0] q, logic rd, logic [7:0] cv,
                              logic [3:0] ak, logic [1:0] o, logic [7:0] yy,
                              logic v, logic bz);
    vec_t t;
    t.rst = r; t.req = q; t.rdy = rd; t.cval = cv;
    t.e_ack = ak; t.e_op = o; t.e_y = yy; t.e_vld = v; t.e_busy = bz;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] q, input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] cv, input logic [7:0] dv, input logic rd);
    bus_rr.req = q; bus_rr.a = av; bus_rr.b = bv; bus_rr.c = cv; bus_rr.d = dv; bus_rr.y_ready = rd;
    bus_fp.req = q; bus_fp.a = av; bus_fp.b = bv; bus_fp.c = cv; bus_fp.d = dv; bus_fp.y_ready = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rr(input string tag, input logic [3:0] ak, input logic [1:0] o,
                        input logic [7:0] yy, input logic v, input logic bz);
    chk({tag, ".ack"},  32'(bus_rr.ack),     32'(ak));
    chk({tag, ".op"},   32'(bus_rr.op),      32'(o));
    chk({tag, ".y"},    32'(bus_rr.y),       32'(yy));
    chk({tag, ".vld"},  32'(bus_rr.y_valid), 32'(v));
    chk({tag, ".busy"}, 32'(bus_rr.busy),    32'(bz));
  endtask

  initial begin
    int grants;
    // reset then idle
    vecs[0]  = mk(1, 4'b0000, 1, 8'h33, 4'b0000, 2'd0, 8'h00, 0, 0);
    vecs[1]  = mk(1, 4'b0000, 1, 8'h33, 4'b0000, 2'd0, 8'h00, 0, 0);
    for (int i = 2; i < 7; i++) vecs[i] = mk(0, 4'b0000, 1, 8'h33, 4'b0000, 2'd0, 8'h00, 0, 0);
    // single request on c
    vecs[7]  = mk(0, 4'b0100, 1, 8'h5A, 4'b0100, 2'd2, 8'h00, 0, 1);
    vecs[8]  = mk(0, 4'b0000, 1, 8'h5A, 4'b0000, 2'd2, 8'h5A, 1, 1);
    vecs[9]  = mk(0, 4'b0000, 1, 8'h5A, 4'b0000, 2'd2, 8'h5A, 0, 0);
    // reset, then round-robin fairness with all four requesting
    vecs[10] = mk(1, 4'b0000, 1, 8'h33, 4'b0000, 2'd0, 8'h00, 0, 0);
    vecs[11] = mk(0, 4'b1111, 1, 8'h33, 4'b0001, 2'd0, 8'h00, 0, 1);
    vecs[12] = mk(0, 4'b1111, 1, 8'h33, 4'b0000, 2'd0, 8'h11, 1, 1);
    vecs[13] = mk(0, 4'b1111, 1, 8'h33, 4'b0000, 2'd0, 8'h11, 0, 0);
    vecs[14] = mk(0, 4'b1111, 1, 8'h33, 4'b0010, 2'd1, 8'h11, 0, 1);
    vecs[15] = mk(0, 4'b1111, 1, 8'h33, 4'b0000, 2'd1, 8'h22, 1, 1);
    vecs[16] = mk(0, 4'b1111, 1, 8'h33, 4'b0000, 2'd1, 8'h22, 0, 0);
    vecs[17] = mk(0, 4'b1111, 1, 8'h33, 4'b0100, 2'd2, 8'h22, 0, 1);
    vecs[18] = mk(0, 4'b1111, 1, 8'h33, 4'b0000, 2'd2, 8'h33, 1, 1);
    vecs[19] = mk(0, 4'b1111, 1, 8'h33, 4'b0000, 2'd2, 8'h33, 0, 0);
    vecs[20] = mk(0, 4'b1111, 1, 8'h33, 4'b1000, 2'd3, 8'h33, 0, 1);
    vecs[21] = mk(0, 4'b1111, 1, 8'h33, 4'b0000, 2'd3, 8'h44, 1, 1);
    vecs[22] = mk(0, 4'b1111, 1, 8'h33, 4'b0000, 2'd3, 8'h44, 0, 0);
    vecs[23] = mk(0, 4'b1111, 1, 8'h33, 4'b0001, 2'd0, 8'h44, 0, 1);
    vecs[24] = mk(0, 4'b0000, 1, 8'h33, 4'b0000, 2'd0, 8'h11, 1, 1);
    vecs[25] = mk(0, 4'b0000, 1, 8'h33, 4'b0000, 2'd0, 8'h11, 0, 0);

    drive(4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    for (int i = 0; i < 26; i++) begin
      rst = vecs[i].rst;
      drive(vecs[i].req, 8'h11, 8'h22, vecs[i].cval, 8'h44, vecs[i].rdy);
      step();
      chk_rr($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_op, vecs[i].e_y,
             vecs[i].e_vld, vecs[i].e_busy);
    end

    // backpressure: a granted with y_ready low, d waits
    rst = 1'b1; drive(4'b0000, 8'hC3, 8'h22, 8'h33, 8'h44, 1'b0); step();
    rst = 1'b0; drive(4'b1001, 8'hC3, 8'h22, 8'h33, 8'h44, 1'b0); step();
    chk_rr("bp_sel", 4'b0001, 2'd0, 8'h00, 0, 1);
    drive(4'b1000, 8'hC3, 8'h22, 8'h33, 8'h44, 1'b0); step();
    chk_rr("bp_hold0", 4'b0000, 2'd0, 8'hC3, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk_rr($sformatf("bp_stall%0d", i), 4'b0000, 2'd0, 8'hC3, 1, 1);
    end
    drive(4'b1000, 8'hC3, 8'h22, 8'h33, 8'h44, 1'b1); step();
    chk_rr("bp_rel", 4'b0000, 2'd0, 8'hC3, 0, 0);
    step();
    chk_rr("bp_d_sel", 4'b1000, 2'd3, 8'hC3, 0, 1);
    drive(4'b0000, 8'hC3, 8'h22, 8'h33, 8'h44, 1'b0); step();
    chk_rr("bp_d_y", 4'b0000, 2'd3, 8'h44, 1, 1);

    // reset during HOLD discards the result and rewinds ptr
    rst = 1'b1; step();
    chk_rr("mid_rst", 4'b0000, 2'd0, 8'h00, 0, 0);
    rst = 1'b0; drive(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1); step();
    chk_rr("post_rst_sel", 4'b0001, 2'd0, 8'h00, 0, 1);

    // fixed priority: b beats d every time
    rst = 1'b1; drive(4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1); step();
    rst = 1'b0; drive(4'b1010, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("fp_no_d%0d", i), 32'(bus_fp.ack[3]), 32'd0);
      if (bus_fp.ack != 4'b0000) begin
        grants++;
        chk($sformatf("fp_ack%0d", i), 32'(bus_fp.ack), 32'b0010);
        chk($sformatf("fp_op%0d", i), 32'(bus_fp.op), 32'd1);
      end
      if (bus_fp.y_valid) chk($sformatf("fp_y%0d", i), 32'(bus_fp.y), 32'h22);
    end
    chk("fp_grants", 32'(grants), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
